// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for port A of the byte-enable BRAM, with in-order read response routing.
// Optional: define BRAM_ARB_FIXED_PRIO_EN for fixed R0 priority (no last_gnt pointer, R1 may starve).
module bram_port_arbiter #(
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int ADDR_W       = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic                        clka,
    input  logic                        rstb,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [ADDR_W-1:0]           req_addr0,
    input  logic [ADDR_W-1:0]           req_addr1,
    input  logic [NB_COL*COL_WIDTH-1:0] req_wdata0,
    input  logic [NB_COL*COL_WIDTH-1:0] req_wdata1,
    input  logic [NB_COL-1:0]           req_be0,
    input  logic [NB_COL-1:0]           req_be1,
    output logic [1:0]                  rsp_valid,
    output logic [NB_COL*COL_WIDTH-1:0] rsp_data,
    output logic                        busy,
    output logic [ADDR_W-1:0]           ram_addra,
    output logic [NB_COL*COL_WIDTH-1:0] ram_dina,
    output logic [NB_COL-1:0]           ram_wea,
    output logic                        ram_ena,
    output logic                        ram_rsta,
    output logic                        ram_regcea,
    input  logic [NB_COL*COL_WIDTH-1:0] ram_douta
);
    localparam int DW = NB_COL * COL_WIDTH;

    logic [1:0]            grant_s;
    logic                  hs_s;
    logic                  sel_s;
    logic [ADDR_W-1:0]     sel_addr_s;
    logic [DW-1:0]         sel_wdata_s;
    logic [NB_COL-1:0]     sel_be_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [DW-1:0]         dina_r;
    logic [NB_COL-1:0]     wea_r;
    logic                  ena_r;
    logic [READ_LATENCY:0] tag_vld_r;
    logic [READ_LATENCY:0] tag_id_r;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic                  last_gnt_r;
`endif

    // Grant selection; last_gnt_r=1 means R1 went last, so R0 wins the next contention
    always_comb begin
        grant_s = 2'b00;
        if (rstb) begin
            grant_s = 2'b00;
        end else begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
`ifdef BRAM_ARB_FIXED_PRIO_EN
                2'b11:   grant_s = 2'b01;
`else
                2'b11:   grant_s = last_gnt_r ? 2'b01 : 2'b10;
`endif
                default: grant_s = 2'b00;
            endcase
        end
    end

    assign hs_s  = |(req_valid & grant_s);
    assign sel_s = grant_s[1];

    // Request field mux for the granted requester
    always_comb begin
        sel_addr_s  = req_addr0;
        sel_wdata_s = req_wdata0;
        sel_be_s    = req_be0;
        if (sel_s) begin
            sel_addr_s  = req_addr1;
            sel_wdata_s = req_wdata1;
            sel_be_s    = req_be1;
        end else begin
            sel_addr_s  = req_addr0;
            sel_wdata_s = req_wdata0;
            sel_be_s    = req_be0;
        end
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    // Round-robin pointer follows the last accepted requester
    always_ff @(posedge clka) begin
        if (rstb) begin
            last_gnt_r <= 1'b1;
        end else if (hs_s) begin
            last_gnt_r <= sel_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`endif

    // RAM port A command register; address and data hold when idle
    always_ff @(posedge clka) begin
        if (rstb) begin
            addr_r <= {ADDR_W{1'b0}};
            dina_r <= {DW{1'b0}};
            wea_r  <= {NB_COL{1'b0}};
            ena_r  <= 1'b0;
        end else if (hs_s) begin
            addr_r <= sel_addr_s;
            dina_r <= sel_wdata_s;
            wea_r  <= sel_be_s;
            ena_r  <= 1'b1;
        end else begin
            wea_r  <= {NB_COL{1'b0}};
            ena_r  <= 1'b0;
        end
    end

    // Read tag pipeline: tag[k] tracks a read k cycles after its command reached the RAM port
    always_ff @(posedge clka) begin
        if (rstb) begin
            tag_vld_r <= {(READ_LATENCY+1){1'b0}};
            tag_id_r  <= {(READ_LATENCY+1){1'b0}};
        end else begin
            tag_vld_r <= {tag_vld_r[READ_LATENCY-1:0], hs_s & (sel_be_s == {NB_COL{1'b0}})};
            tag_id_r  <= {tag_id_r[READ_LATENCY-1:0], sel_s};
        end
    end

    // Response strobe for the requester owning the oldest tag
    always_comb begin
        rsp_valid = 2'b00;
        if (!rstb && tag_vld_r[READ_LATENCY]) begin
            rsp_valid = tag_id_r[READ_LATENCY] ? 2'b10 : 2'b01;
        end else begin
            rsp_valid = 2'b00;
        end
    end

    // Reset forces every RAM control to its idle value immediately, not one edge later
    assign req_ready  = grant_s;
    assign rsp_data   = ram_douta;
    assign busy       = (|tag_vld_r) & ~rstb;
    assign ram_addra  = rstb ? {ADDR_W{1'b0}} : addr_r;
    assign ram_dina   = rstb ? {DW{1'b0}} : dina_r;
    assign ram_wea    = rstb ? {NB_COL{1'b0}} : wea_r;
    assign ram_ena    = ena_r & ~rstb;
    assign ram_rsta   = rstb;
    assign ram_regcea = (READ_LATENCY == 2) ? (tag_vld_r[READ_LATENCY-1] & ~rstb) : 1'b0;

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter sharing port A of the team's byte-enable dual-port block RAM between two requesters (R0, R1). Each requester has a valid/ready request channel carrying address, write data and byte enables. Read responses are routed back to the originating requester with a fixed latency. The block sits directly in front of the RAM's port A and drives all of its control inputs; port B stays free for an independent agent.

## Interface
- NB_COL, 4, byte lanes per word
- COL_WIDTH, 8, bits per lane
- ADDR_W, 9, address width (RAM depth 512)
- READ_LATENCY, 2, RAM output latency: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE; other values illegal
- clka  in  1  clock for the block and the RAM port
- rstb  in  1  reset; synchronous, active-high; clock clka
- req_valid  in  2  per-requester request valid (bit i = Ri)
- req_ready  out  2  per-requester accept; one-hot or zero
- req_addr0 / req_addr1  in  ADDR_W  request address
- req_wdata0 / req_wdata1  in  NB_COL*COL_WIDTH  write data
- req_be0 / req_be1  in  NB_COL  byte enables; all-zero = read
- rsp_valid  out  2  read-response strobe, one-hot or zero
- rsp_data  out  NB_COL*COL_WIDTH  read data, shared by both requesters
- busy  out  1  high while any accepted read has not yet responded
- ram_addra  out  ADDR_W  to RAM addra
- ram_dina  out  NB_COL*COL_WIDTH  to RAM dina
- ram_wea  out  NB_COL  to RAM wea
- ram_ena  out  1  to RAM ena
- ram_rsta  out  1  to RAM rsta
- ram_regcea  out  1  to RAM regcea
- ram_douta  in  NB_COL*COL_WIDTH  from RAM douta

## Operation
- Grant logic is combinational from req_valid and the pointer last_gnt.
  - Only one requester valid: that requester is granted.
  - Both valid: grant ~last_gnt.
  - req_ready = grant. Handshake = valid & ready.
- last_gnt updates to the granted index on every handshake. Reset value is 1, so R0 wins the first contention.
- On a handshake, the granted requester's addr/wdata/be are registered into ram_addra/ram_dina/ram_wea, with ram_ena=1.
- With no handshake: ram_ena=0 and ram_wea=0. Address and data hold their previous values.
- Tag pipeline tag[0..READ_LATENCY], each entry {valid, id}:
  - tag[0] is loaded on a handshake with be==0 (reads only).
  - Entries shift every cycle.
- rsp_valid[id] = tag[READ_LATENCY].valid.
- rsp_data = ram_douta, passed through combinationally.
- Writes produce no response.
- ram_regcea = tag[READ_LATENCY-1].valid when READ_LATENCY=2. Tie to 0 when READ_LATENCY=1.
- ram_rsta = rstb.
- busy = OR of all tag valids.
- Requesters must always accept responses; there is no response backpressure.
- Requests are never dropped. An unaccepted request must be held stable until ready.

## Timing
- Reset values, held while rstb=1:
  - req_ready=0, rsp_valid=0, busy=0
  - ram_ena=0, ram_wea=0, ram_regcea=0
  - ram_addra=0, ram_dina=0
  - all tags invalid, last_gnt=1
- Throughput: one request per cycle. Back-to-back handshakes from the same or alternating requesters are allowed.
- Read latency: handshake at edge N -> rsp_valid high in the cycle after edge N+READ_LATENCY+1, with matching data. That is 2 cycles for LOW_LATENCY, 3 for HIGH_PERFORMANCE.
- Responses return strictly in acceptance order.
- Writes: RAM written at edge N+1.
  - A read of the same address accepted at N+1 sees the new data.
  - Reads accepted at N itself are in the same RAM cycle as nothing else.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid follows. The RAM output register is cleared through ram_rsta.
- Sustained contention alternates R0, R1, R0, … every cycle.

## Configuration
- BRAM_ARB_FIXED_PRIO_EN:
  - Defined: R0 always wins when both are valid. last_gnt is not implemented and R1 may starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset then single read: R0 reads addr 0x010 (preloaded 0xDEADBEEF), READ_LATENCY=2 -> rsp_valid=2'b01 exactly 3 cycles after the handshake, rsp_data=0xDEADBEEF, busy high for those cycles.
- Byte write then read: R1 writes 0x11223344 be=4'b0101 to 0x020 (old 0xAABBCCDD), then reads it -> rsp_valid=2'b10, rsp_data=0xAA22CC44; no response for the write.
- Contention: both valid continuously for 6 cycles -> grants R0,R1,R0,R1,R0,R1. With BRAM_ARB_FIXED_PRIO_EN -> six R0 grants and R1 req_ready=0 throughout.
- Back-to-back mixed reads: R0@1, R1@2, R0@3 on consecutive cycles with READ_LATENCY=1 -> responses on three consecutive cycles, 2 cycles after each handshake, ids 01,10,01 in order.
- Reset mid-flight: assert rstb one cycle after a read handshake -> rsp_valid never asserts, busy=0, and ram_ena=0 while rstb is high.
- Idle: no req_valid for 10 cycles -> ram_ena=0, ram_wea=0, req_ready=0, rsp_valid=0.
